ddr4_dram_responder: RTL and testbench

// - DRAM-side model for the open-page memory controller: consumes PRE/ACT/RD/WR commands, one per cycle.
// - Tracks 16 banks (4 bank groups x 4 banks) and checks every command against bank state and mc_defs timing.
// - Returns a per-command status one cycle later.
// - Returns read-data beats tCAS cycles after each accepted RD.

---
 rtl/ddr4_dram_responder_pkg.sv | 65 ++++++
 rtl/ddr4_bank_timer.sv | 73 +++++++
 rtl/ddr4_dram_responder.sv | 177 +++++++++++++++++
 tb/tb_ddr4_dram_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_dram_responder_pkg.sv
// DDR4 DRAM responder shared types and timing.
// Timing constants mirror the memory controller defaults.
package ddr4_resp_pkg;

  localparam int CW      = 8;
  localparam int T_RP    = 24;
  localparam int T_RCD   = 24;
  localparam int T_CAS   = 24;
  localparam int T_RAS   = 52;
  localparam int T_RC    = 76;
  localparam int T_RTP   = 12;
  localparam int T_CWD   = 20;
  localparam int T_WR    = 20;
  localparam int T_BURST = 4;
  localparam int T_RRD_L = 6;
  localparam int T_RRD_S = 4;
  localparam int T_CCD_L = 8;
  localparam int T_CCD_S = 4;
  localparam int T_WTR_L = 12;
  localparam int T_WTR_S = 4;

  localparam int T_WR_PRE   = T_CWD + T_BURST + T_WR;
  localparam int T_WR_RD_L  = T_CWD + T_BURST + T_WTR_L;
  localparam int T_WR_RD_S  = T_CWD + T_BURST + T_WTR_S;
  localparam int CNT_LIM    = (1 << CW) - 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_PRE = 3'd1,
    CMD_ACT = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_STATE   = 2'd1,
    ERR_TIMING  = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_e;

  typedef enum logic {
    B_CLOSED = 1'b0,
    B_OPEN   = 1'b1
  } bank_state_e;

  typedef struct packed {
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [14:0] row;
    logic [6:0]  col;
  } tag_t;

  function automatic cnt_t sat_inc(cnt_t c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic cnt_t thr(int t);
    return cnt_t'(t);
  endfunction

endpackage

// File: rtl/ddr4_bank_timer.sv
// One DDR4 bank: open/closed state, open row
// and the per-bank elapsed-cycle counters.
module ddr4_bank_timer
  import ddr4_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        do_act,
  input  logic        do_pre,
  input  logic        do_rd,
  input  logic        do_wr,
  input  logic [14:0] row,
  output logic        is_open,
  output logic [14:0] open_row,
  output logic        act_ok,
  output logic        pre_ok,
  output logic        rd_ok,
  output logic        wr_ok
);

  bank_state_e state_q;
  bank_state_e state_d;
  cnt_t since_act;
  cnt_t since_pre;
  cnt_t since_rd;
  cnt_t since_wr;

  // Bank state register and latched row
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= B_CLOSED;
      open_row <= '0;
    end else begin
      state_q <= state_d;
      if (do_act) open_row <= row;
    end
  end

  // Next bank state: ACT opens, PRE closes
  always_comb begin
    state_d = state_q;
    if (do_act)      state_d = B_OPEN;
    else if (do_pre) state_d = B_CLOSED;
  end

  // Saturating elapsed-cycle counters, restarted on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      since_act <= CNT_MAX;
      since_pre <= CNT_MAX;
      since_rd  <= CNT_MAX;
      since_wr  <= CNT_MAX;
    end else begin
      since_act <= do_act ? cnt_t'(1) : sat_inc(since_act);
      since_pre <= do_pre ? cnt_t'(1) : sat_inc(since_pre);
      since_rd  <= do_rd  ? cnt_t'(1) : sat_inc(since_rd);
      since_wr  <= do_wr  ? cnt_t'(1) : sat_inc(since_wr);
    end
  end

  assign is_open = (state_q == B_OPEN);

  assign act_ok = (since_pre >= thr(T_RP))
                & (since_act >= thr(T_RC));

  assign pre_ok = (since_act >= thr(T_RAS))
                & (since_rd  >= thr(T_RTP))
                & (since_wr  >= thr(T_WR_PRE));

  assign rd_ok = (since_act >= thr(T_RCD));
  assign wr_ok = (since_act >= thr(T_RCD));

endmodule

// File: rtl/ddr4_dram_responder.sv
// DDR4 DRAM-side responder: command checking,
// per-command status and read-data beat return.
module ddr4_dram_responder
  import ddr4_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_bg,
  input  logic [1:0]  cmd_ba,
  input  logic [14:0] cmd_row,
  input  logic [10:0] cmd_col,
  output logic        resp_valid,
  output logic [1:0]  resp_err,
  output logic        rd_valid,
  output logic [1:0]  rd_beat,
  output logic [25:0] rd_tag,
  output logic [15:0] bank_open
);

  localparam int DEPTH = T_CAS + T_BURST - 1;

  if (T_RC > CNT_LIM || T_RAS > CNT_LIM ||
      T_WR_PRE > CNT_LIM || T_WR_RD_L > CNT_LIM ||
      T_WR_RD_S > CNT_LIM || T_RP > CNT_LIM ||
      T_RCD > CNT_LIM) begin : g_cw_chk
    $error("timing threshold exceeds counter width");
  end

  cmd_e        op;
  err_e        err;
  logic [3:0]  sel;
  logic        accept;
  logic [15:0] onehot;
  logic [15:0] do_act, do_pre, do_rd, do_wr;
  logic [15:0] act_ok, pre_ok, rd_ok, wr_ok;
  logic [14:0] open_row [16];

  cnt_t        since_act_g, since_col_g, since_wr_g;
  logic [1:0]  last_act_bg, last_col_bg, last_wr_bg;
  cnt_t        rrd_thr, ccd_thr, wtr_thr;

  logic [DEPTH-1:0] pv;
  tag_t             pt [DEPTH];
  tag_t             new_tag;
  logic             unused_col;

  assign op     = cmd_e'(cmd_op);
  assign sel    = {cmd_bg, cmd_ba};
  assign onehot = 16'(1) << sel;
  assign accept = cmd_valid & (err == ERR_OK);
  assign unused_col = ^cmd_col[10:7];

  assign do_act = (accept && op == CMD_ACT) ? onehot : '0;
  assign do_pre = (accept && op == CMD_PRE) ? onehot & bank_open : '0;
  assign do_rd  = (accept && op == CMD_RD)  ? onehot : '0;
  assign do_wr  = (accept && op == CMD_WR)  ? onehot : '0;

  for (genvar i = 0; i < 16; i++) begin : g_bank
    ddr4_bank_timer u_bank (
      .clk      (clk),
      .rst      (rst),
      .do_act   (do_act[i]),
      .do_pre   (do_pre[i]),
      .do_rd    (do_rd[i]),
      .do_wr    (do_wr[i]),
      .row      (cmd_row),
      .is_open  (bank_open[i]),
      .open_row (open_row[i]),
      .act_ok   (act_ok[i]),
      .pre_ok   (pre_ok[i]),
      .rd_ok    (rd_ok[i]),
      .wr_ok    (wr_ok[i])
    );
  end

  assign rrd_thr = (cmd_bg == last_act_bg) ? thr(T_RRD_L) : thr(T_RRD_S);
  assign ccd_thr = (cmd_bg == last_col_bg) ? thr(T_CCD_L) : thr(T_CCD_S);
  assign wtr_thr = (cmd_bg == last_wr_bg)  ? thr(T_WR_RD_L) : thr(T_WR_RD_S);

  // Priority error mux: illegal, then state, then timing
  always_comb begin
    err = ERR_OK;
    case (op)
      CMD_NOP: err = ERR_OK;
      CMD_ACT:
        if (bank_open[sel])
          err = ERR_STATE;
        else if (!(act_ok[sel] && since_act_g >= rrd_thr))
          err = ERR_TIMING;
      CMD_PRE:
        if (bank_open[sel] && !pre_ok[sel])
          err = ERR_TIMING;
      CMD_RD:
        if (!bank_open[sel])
          err = ERR_STATE;
        else if (!(rd_ok[sel] && since_col_g >= ccd_thr
                   && since_wr_g >= wtr_thr))
          err = ERR_TIMING;
      CMD_WR:
        if (!bank_open[sel])
          err = ERR_STATE;
        else if (!(wr_ok[sel] && since_col_g >= ccd_thr))
          err = ERR_TIMING;
      default: err = ERR_ILLEGAL;
    endcase
  end

  // Status register, one cycle behind the command
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= cmd_valid;
      resp_err   <= cmd_valid ? err : ERR_OK;
    end
  end

  // Global ACT / column / write counters and their bank groups
  always_ff @(posedge clk) begin
    if (rst) begin
      since_act_g <= CNT_MAX;
      since_col_g <= CNT_MAX;
      since_wr_g  <= CNT_MAX;
      last_act_bg <= '0;
      last_col_bg <= '0;
      last_wr_bg  <= '0;
    end else begin
      since_act_g <= sat_inc(since_act_g);
      since_col_g <= sat_inc(since_col_g);
      since_wr_g  <= sat_inc(since_wr_g);
      if (|do_act) begin
        since_act_g <= cnt_t'(1);
        last_act_bg <= cmd_bg;
      end
      if (|do_rd || |do_wr) begin
        since_col_g <= cnt_t'(1);
        last_col_bg <= cmd_bg;
      end
      if (|do_wr) begin
        since_wr_g <= cnt_t'(1);
        last_wr_bg <= cmd_bg;
      end
    end
  end

  assign new_tag = '{bg: cmd_bg, ba: cmd_ba,
                     row: open_row[sel], col: cmd_col[6:0]};

  // Read return shift register of {valid, tag}
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv <= {pv[DEPTH-2:0], |do_rd};
    end
    pt[0] <= new_tag;
    for (int i = 1; i < DEPTH; i++) pt[i] <= pt[i-1];
  end

  // Beat window taps: stage T_CAS-1+b carries beat b
  always_comb begin
    rd_valid = 1'b0;
    rd_beat  = '0;
    rd_tag   = '0;
    for (int b = 0; b < T_BURST; b++) begin
      if (pv[T_CAS-1+b]) begin
        rd_valid = 1'b1;
        rd_beat  = 2'(b);
        rd_tag   = pt[T_CAS-1+b];
      end
    end
  end

endmodule

// File: tb/tb_ddr4_dram_responder.sv
// Directed testbench for ddr4_dram_responder.
// Times are cycles relative to each scenario's first command.
module tb_ddr4_dram_responder;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] PRE = 3'd1;
  localparam logic [2:0] ACT = 3'd2;
  localparam logic [2:0] RD  = 3'd3;
  localparam logic [2:0] WR  = 3'd4;
  localparam logic [1:0] OK  = 2'd0;
  localparam logic [1:0] STA = 2'd1;
  localparam logic [1:0] TIM = 2'd2;
  localparam logic [1:0] ILL = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [1:0]  cmd_bg = '0;
  logic [1:0]  cmd_ba = '0;
  logic [14:0] cmd_row = '0;
  logic [10:0] cmd_col = '0;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic        rd_valid;
  logic [1:0]  rd_beat;
  logic [25:0] rd_tag;
  logic [15:0] bank_open;

  int cyc = 0;
  int t0 = 0;
  int n_chk = 0;
  int n_fail = 0;

  ddr4_dram_responder dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_bg     (cmd_bg),
    .cmd_ba     (cmd_ba),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .rd_valid   (rd_valid),
    .rd_beat    (rd_beat),
    .rd_tag     (rd_tag),
    .bank_open  (bank_open)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc - t0 < t) step();
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] bg,
                       input logic [1:0] ba, input logic [14:0] row,
                       input logic [10:0] col, output logic [2:0] r);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_bg = bg;
    cmd_ba = ba;
    cmd_row = row;
    cmd_col = col;
    step();
    r = {resp_valid, resp_err};
    cmd_valid = 1'b0;
    cmd_op = NOP;
  endtask

  task automatic test_reset();
    logic [47:0] o;
    do_reset();
    o = {resp_valid, resp_err, rd_valid, rd_beat, rd_tag, bank_open};
    n_chk++;
    if (o !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
  endtask

  task automatic test_basic_read();
    logic [2:0] r;
    logic [25:0] exp_tag;
    exp_tag = {2'd0, 2'd0, 15'd5, 7'd8};
    do_reset();
    issue(ACT, 2'd0, 2'd0, 15'd5, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK}) begin
      n_fail++; $display("FAIL basic_act: got %b want %b", r, {1'b1, OK});
    end
    n_chk++;
    if (bank_open !== 16'h0001) begin
      n_fail++; $display("FAIL basic_open: got %h want 0001", bank_open);
    end
    goto(24);
    issue(RD, 2'd0, 2'd0, 15'd0, 11'd8, r);
    n_chk++;
    if (r !== {1'b1, OK}) begin
      n_fail++; $display("FAIL basic_rd: got %b want %b", r, {1'b1, OK});
    end
    while (cyc - t0 <= 54) begin
      int rel;
      logic ev;
      rel = cyc - t0;
      ev = (rel >= 48 && rel <= 51);
      n_chk++;
      if (rd_valid !== ev) begin
        n_fail++;
        $display("FAIL basic_rdv@%0d: got %b want %b", rel, rd_valid, ev);
      end
      if (ev) begin
        n_chk++;
        if (rd_beat !== 2'(rel - 48) || rd_tag !== exp_tag) begin
          n_fail++;
          $display("FAIL basic_beat@%0d: got %0d/%h want %0d/%h",
                   rel, rd_beat, rd_tag, rel - 48, exp_tag);
        end
      end
      step();
    end
  endtask

  task automatic test_rcd_ras();
    logic [2:0] r;
    do_reset();
    issue(ACT, 2'd0, 2'd0, 15'd1, 11'd0, r);
    goto(23);
    issue(RD, 2'd0, 2'd0, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, TIM}) begin
      n_fail++; $display("FAIL rcd_early: got %b want %b", r, {1'b1, TIM});
    end
    issue(RD, 2'd0, 2'd0, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK}) begin
      n_fail++; $display("FAIL rcd_ok: got %b want %b", r, {1'b1, OK});
    end
    goto(51);
    issue(PRE, 2'd0, 2'd0, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, TIM}) begin
      n_fail++; $display("FAIL ras_early: got %b want %b", r, {1'b1, TIM});
    end
    issue(PRE, 2'd0, 2'd0, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK} || bank_open !== 16'h0) begin
      n_fail++;
      $display("FAIL ras_ok: got %b/%h want %b/0000", r, bank_open, {1'b1, OK});
    end
  endtask

  task automatic test_rrd();
    logic [2:0] r;
    do_reset();
    issue(ACT, 2'd0, 2'd0, 15'd1, 11'd0, r);
    goto(4);
    issue(ACT, 2'd1, 2'd0, 15'd2, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK}) begin
      n_fail++; $display("FAIL rrd_s_ok: got %b want %b", r, {1'b1, OK});
    end
    issue(ACT, 2'd0, 2'd1, 15'd3, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, TIM}) begin
      n_fail++; $display("FAIL rrd_early: got %b want %b", r, {1'b1, TIM});
    end
    goto(9);
    issue(ACT, 2'd1, 2'd1, 15'd4, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, TIM}) begin
      n_fail++; $display("FAIL rrd_l_early: got %b want %b", r, {1'b1, TIM});
    end
    issue(ACT, 2'd1, 2'd1, 15'd4, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK} || bank_open !== 16'h0031) begin
      n_fail++;
      $display("FAIL rrd_l_ok: got %b/%h want %b/0031", r, bank_open, {1'b1, OK});
    end
  endtask

  task automatic test_state_illegal();
    logic [2:0] r;
    do_reset();
    issue(RD, 2'd2, 2'd3, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, STA}) begin
      n_fail++; $display("FAIL rd_closed: got %b want %b", r, {1'b1, STA});
    end
    issue(ACT, 2'd2, 2'd3, 15'd7, 11'd0, r);
    issue(ACT, 2'd2, 2'd3, 15'd7, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, STA}) begin
      n_fail++; $display("FAIL act_open: got %b want %b", r, {1'b1, STA});
    end
    issue(3'd7, 2'd0, 2'd0, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, ILL} || bank_open !== 16'h0800) begin
      n_fail++;
      $display("FAIL illegal: got %b/%h want %b/0800", r, bank_open, {1'b1, ILL});
    end
    issue(NOP, 2'd0, 2'd0, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK}) begin
      n_fail++; $display("FAIL nop: got %b want %b", r, {1'b1, OK});
    end
    step();
    n_chk++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_resp: got %b want 0", resp_valid);
    end
    issue(PRE, 2'd3, 2'd3, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK} || bank_open !== 16'h0800) begin
      n_fail++;
      $display("FAIL pre_closed: got %b/%h want %b/0800", r, bank_open, {1'b1, OK});
    end
    goto(8);
    issue(ACT, 2'd3, 2'd3, 15'd9, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK} || bank_open !== 16'h8800) begin
      n_fail++;
      $display("FAIL act_after_pre_closed: got %b/%h want %b/8800",
               r, bank_open, {1'b1, OK});
    end
  endtask

  task automatic test_write_turnaround();
    logic [2:0] r;
    do_reset();
    issue(ACT, 2'd1, 2'd2, 15'd3, 11'd0, r);
    goto(30);
    issue(WR, 2'd1, 2'd2, 15'd0, 11'd4, r);
    n_chk++;
    if (r !== {1'b1, OK}) begin
      n_fail++; $display("FAIL wr_ok: got %b want %b", r, {1'b1, OK});
    end
    goto(65);
    issue(RD, 2'd1, 2'd2, 15'd0, 11'd4, r);
    n_chk++;
    if (r !== {1'b1, TIM}) begin
      n_fail++; $display("FAIL wtr_early: got %b want %b", r, {1'b1, TIM});
    end
    issue(RD, 2'd1, 2'd2, 15'd0, 11'd4, r);
    n_chk++;
    if (r !== {1'b1, OK}) begin
      n_fail++; $display("FAIL wtr_ok: got %b want %b", r, {1'b1, OK});
    end
    goto(73);
    issue(PRE, 2'd1, 2'd2, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, TIM}) begin
      n_fail++; $display("FAIL wr_pre_early: got %b want %b", r, {1'b1, TIM});
    end
    goto(77);
    issue(PRE, 2'd1, 2'd2, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, TIM}) begin
      n_fail++; $display("FAIL rtp_early: got %b want %b", r, {1'b1, TIM});
    end
    issue(PRE, 2'd1, 2'd2, 15'd0, 11'd0, r);
    n_chk++;
    if (r !== {1'b1, OK} || bank_open !== 16'h0) begin
      n_fail++;
      $display("FAIL pre_ok: got %b/%h want %b/0000", r, bank_open, {1'b1, OK});
    end
  endtask

  task automatic two_reads();
    logic [2:0] r;
    do_reset();
    issue(ACT, 2'd0, 2'd0, 15'd5, 11'd0, r);
    goto(4);
    issue(ACT, 2'd1, 2'd0, 15'd9, 11'd0, r);
    goto(24);
    issue(RD, 2'd0, 2'd0, 15'd0, 11'd1, r);
    goto(28);
    issue(RD, 2'd1, 2'd0, 15'd0, 11'd2, r);
    n_chk++;
    if (r !== {1'b1, OK}) begin
      n_fail++; $display("FAIL ccd_s_rd: got %b want %b", r, {1'b1, OK});
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] t1, t2, et;
    t1 = {2'd0, 2'd0, 15'd5, 7'd1};
    t2 = {2'd1, 2'd0, 15'd9, 7'd2};
    two_reads();
    while (cyc - t0 <= 57) begin
      int rel;
      logic ev;
      rel = cyc - t0;
      ev = (rel >= 48 && rel <= 55);
      et = (rel < 52) ? t1 : t2;
      n_chk++;
      if (rd_valid !== ev) begin
        n_fail++;
        $display("FAIL b2b_rdv@%0d: got %b want %b", rel, rd_valid, ev);
      end
      if (ev) begin
        n_chk++;
        if (rd_beat !== 2'((rel - 48) % 4) || rd_tag !== et) begin
          n_fail++;
          $display("FAIL b2b_beat@%0d: got %0d/%h want %0d/%h",
                   rel, rd_beat, rd_tag, (rel - 48) % 4, et);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_burst();
    two_reads();
    while (cyc - t0 <= 57) begin
      int rel;
      logic ev;
      rel = cyc - t0;
      ev = (rel == 48 || rel == 49);
      n_chk++;
      if (rd_valid !== ev) begin
        n_fail++;
        $display("FAIL rst_rdv@%0d: got %b want %b", rel, rd_valid, ev);
      end
      if (rel == 50) begin
        n_chk++;
        if (bank_open !== 16'h0) begin
          n_fail++; $display("FAIL rst_banks: got %h want 0000", bank_open);
        end
      end
      rst = (rel == 49);
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_rcd_ras();
    test_rrd();
    test_state_illegal();
    test_write_turnaround();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
